jtag_spi_bridge: RTL and testbench

JTAG_SPI_BRIDGE -- requirements
Module: jtag_spi_bridge

---
 rtl/jtag_spi_bridge.sv | 158 +++++++++++++++
 tb/tb_jtag_spi_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_spi_bridge.sv
// JTAG user-DR to SPI bridge: hunts for a sync header in the scan stream, runs one
// SPI burst per header and records MISO into a buffer that later scans read back on tdo.
module jtag_spi_bridge #(
  parameter int          LEN_W  = 16,
  parameter int          BUF_AW = 14,
  parameter int          CS_N   = 1,
  parameter logic [31:0] MAGIC  = 32'h59A659A6
) (
  input  logic            drck,
  input  logic            rst,
  input  logic            sel,
  input  logic            capture,
  input  logic            update,
  input  logic            shift,
  input  logic            tdi,
  output logic            tdo,
  output logic            spi_sck,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic [CS_N-1:0] spi_cs_n,
  output logic            busy,
  output logic            ovf,
  output logic            err
);

  localparam int H    = 32 + 8 + LEN_W;
  localparam int WA_W = BUF_AW + 1;

  typedef enum logic [1:0] {HUNT, XFER, GAP} state_t;

  logic sess_rst;
  logic flag_rst;
  assign sess_rst = rst | capture | update | ~sel;
  assign flag_rst = rst | capture;

  // drck only runs while shifting, so the shift strobe carries no extra information
  logic unused_shift;
  assign unused_shift = shift;

  state_t            state_reg, state_next;
  logic [H-1:0]      hdr_reg, hdr_next;
  logic [LEN_W-1:0]  cnt_reg, cnt_next;
  logic [7:0]        idx_reg, idx_next;
  logic [WA_W-1:0]   waddr_reg, waddr_next;
  logic [BUF_AW-1:0] raddr_reg;
  logic              ovf_reg, err_reg;
  logic              rd_bit_reg, tdo_reg;
  logic [CS_N-1:0]   cs_n_reg, cs_next;
  logic              err_set, ovf_set, wr_en;

  logic [H-1:0]     shifted;
  logic [7:0]       hdr_idx;
  logic [LEN_W-1:0] hdr_len;
  assign shifted = {hdr_reg[H-2:0], tdi};
  assign hdr_idx = shifted[LEN_W +: 8];
  assign hdr_len = shifted[LEN_W-1:0];

  // Writes stop once the pointer has walked off the end; it saturates rather than wraps
  assign wr_en   = (state_reg == XFER) && !ovf_reg && !waddr_reg[BUF_AW];
  assign ovf_set = (state_reg == XFER) && !waddr_reg[BUF_AW] && (&waddr_reg[BUF_AW-1:0]);

  always_comb begin
    state_next = state_reg;
    hdr_next   = hdr_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    waddr_next = waddr_reg;
    err_set    = 1'b0;
    case (state_reg)
      HUNT: begin
        hdr_next = shifted;
        if (shifted[H-1 -: 32] == MAGIC) begin
          hdr_next = '0;
          if ({1'b0, hdr_idx} >= 9'(CS_N)) begin
            err_set = 1'b1;
          end else if (hdr_len != '0) begin
            cnt_next   = hdr_len;
            idx_next   = hdr_idx;
            state_next = XFER;
          end
        end
      end
      XFER: begin
        cnt_next = cnt_reg - LEN_W'(1);
        if (!waddr_reg[BUF_AW]) waddr_next = waddr_reg + WA_W'(1);
        if (cnt_reg == LEN_W'(1)) state_next = GAP;
      end
      GAP: begin
        hdr_next   = '0;
        state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge drck or posedge sess_rst) begin
    if (sess_rst) begin
      state_reg <= HUNT;
      hdr_reg   <= '0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      waddr_reg <= '0;
      raddr_reg <= '0;
    end else begin
      state_reg <= state_next;
      hdr_reg   <= hdr_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      waddr_reg <= waddr_next;
      raddr_reg <= raddr_reg + BUF_AW'(1);
    end
  end

  // Sticky flags survive update/deselect so the host can inspect them on a later scan
  always_ff @(posedge drck or posedge flag_rst) begin
    if (flag_rst) begin
      ovf_reg <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      if (ovf_set) ovf_reg <= 1'b1;
      if (err_set) err_reg <= 1'b1;
    end
  end

  // Readback buffer deliberately has no reset so contents persist across sessions
  logic buf_mem [2**BUF_AW];
  always_ff @(posedge drck) begin
    if (wr_en) buf_mem[waddr_reg[BUF_AW-1:0]] <= spi_miso;
    rd_bit_reg <= buf_mem[raddr_reg];
  end

  genvar gi;
  generate
    for (gi = 0; gi < CS_N; gi++) begin : g_cs
      assign cs_next[gi] = !((state_reg == XFER) && (idx_reg == 8'(gi)));
    end
  endgenerate

  // Falling-edge launch gives the slave half a period of setup on CS and the host on tdo
  always_ff @(negedge drck or posedge sess_rst) begin
    if (sess_rst) begin
      cs_n_reg <= '1;
      tdo_reg  <= 1'b0;
    end else begin
      cs_n_reg <= cs_next;
      tdo_reg  <= rd_bit_reg;
    end
  end

  assign spi_sck  = drck;
  assign spi_mosi = tdi;
  assign spi_cs_n = cs_n_reg;
  assign tdo      = tdo_reg;
  assign busy     = (state_reg != HUNT);
  assign ovf      = ovf_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_jtag_spi_bridge.sv
// Directed bench for jtag_spi_bridge: a two-select instance with a large buffer and a
// one-select instance with an 8-bit buffer share the same scan stimulus.
module tb_jtag_spi_bridge;

  localparam logic [31:0] MAGIC = 32'h59A659A6;

  logic drck = 1'b0, rst = 1'b0, sel = 1'b1, capture = 1'b0, update = 1'b0;
  logic shift = 1'b1, tdi = 1'b0, spi_miso = 1'b0;

  logic       tdo, sck, mosi, busy, ovf, err;
  logic [1:0] cs_n;
  logic       tdo_s, sck_s, mosi_s, busy_s, ovf_s, err_s;
  logic [0:0] cs_s;

  jtag_spi_bridge #(.CS_N(2)) u_dut (
    .drck(drck), .rst(rst), .sel(sel), .capture(capture), .update(update), .shift(shift),
    .tdi(tdi), .tdo(tdo), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(spi_miso),
    .spi_cs_n(cs_n), .busy(busy), .ovf(ovf), .err(err)
  );

  jtag_spi_bridge #(.BUF_AW(3)) u_small (
    .drck(drck), .rst(rst), .sel(sel), .capture(capture), .update(update), .shift(shift),
    .tdi(tdi), .tdo(tdo_s), .spi_sck(sck_s), .spi_mosi(mosi_s), .spi_miso(spi_miso),
    .spi_cs_n(cs_s), .busy(busy_s), .ovf(ovf_s), .err(err_s)
  );

  int checks = 0;
  int failures = 0;
  int c0, c1, cs_small, nbusy;
  logic [1:0] cs_log[$];

  typedef struct {
    logic [7:0]  idx;
    logic [15:0] len;
    logic [31:0] miso;
    int          e_c0;
    int          e_c1;
    int          e_busy;
    logic        e_err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One scan bit; CS/busy are sampled just before the rising edge.
  task automatic clk_bit(input logic b, input logic m);
    tdi = b;
    spi_miso = m;
    #2;
    if (!cs_n[0]) c0++;
    if (!cs_n[1]) c1++;
    if (!cs_s[0]) cs_small++;
    if (busy) nbusy++;
    cs_log.push_back(cs_n);
    drck = 1'b1;
    #3;
    drck = 1'b0;
    #5;
  endtask

  task automatic clear_counts();
    c0 = 0; c1 = 0; cs_small = 0; nbusy = 0;
    cs_log.delete();
  endtask

  task automatic pulse_capture();
    #1 capture = 1'b1;
    #2 capture = 1'b0;
    #1;
  endtask

  task automatic pulse_update();
    #1 update = 1'b1;
    #2 update = 1'b0;
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] idx, input logic [15:0] len);
    logic [55:0] h;
    h = {MAGIC, idx, len};
    for (int i = 55; i >= 0; i--) clk_bit(h[i], 1'b0);
  endtask

  task automatic send_data(input int len, input logic [31:0] m);
    for (int j = len - 1; j >= 0; j--) clk_bit(1'b0, m[j]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_bit(1'b0, 1'b0);
  endtask

  // New session, then n scan bits; captured bit k is expected after the (k+1)th falling edge.
  task automatic readback(input int n, output logic [31:0] obs, output logic [31:0] obs_s);
    obs = '0;
    obs_s = '0;
    pulse_update();
    for (int k = 0; k < n; k++) begin
      clk_bit(1'b0, 1'b0);
      obs[n-1-k] = tdo;
      obs_s[n-1-k] = tdo_s;
    end
  endtask

  logic [31:0] obs, obs_s, mask;
  int last1, first0, overlap;

  initial begin
    vecs[0] = '{8'd0, 16'd8,  32'h0000_00A5, 8,  0, 9,  1'b0};
    vecs[1] = '{8'd1, 16'd5,  32'h0000_0016, 0,  5, 6,  1'b0};
    vecs[2] = '{8'd0, 16'd0,  32'h0000_0000, 0,  0, 0,  1'b0};
    vecs[3] = '{8'd5, 16'd3,  32'h0000_0007, 0,  0, 0,  1'b1};
    vecs[4] = '{8'd2, 16'd4,  32'h0000_000F, 0,  0, 0,  1'b1};
    vecs[5] = '{8'd1, 16'd1,  32'h0000_0001, 0,  1, 2,  1'b0};
    vecs[6] = '{8'd0, 16'd16, 32'h0000_C35A, 16, 0, 17, 1'b0};

    #1 rst = 1'b1;
    #5 rst = 1'b0;
    #4;
    check("reset_cs_n", 32'(cs_n), 32'h3);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_tdo", 32'(tdo), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);

    for (int v = 0; v < 7; v++) begin
      pulse_capture();
      clear_counts();
      send_hdr(vecs[v].idx, vecs[v].len);
      send_data(int'(vecs[v].len), vecs[v].miso);
      idle(3);
      check($sformatf("v%0d_cs0_edges", v), 32'(c0), 32'(vecs[v].e_c0));
      check($sformatf("v%0d_cs1_edges", v), 32'(c1), 32'(vecs[v].e_c1));
      check($sformatf("v%0d_busy_edges", v), 32'(nbusy), 32'(vecs[v].e_busy));
      check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].e_err));
      check($sformatf("v%0d_ovf", v), 32'(ovf), 32'h0);
      if (!vecs[v].e_err && vecs[v].len != 16'd0) begin
        readback(int'(vecs[v].len), obs, obs_s);
        mask = (32'd1 << vecs[v].len) - 32'd1;
        check($sformatf("v%0d_readback", v), obs, vecs[v].miso & mask);
      end
    end

    // Two commands in one scan, second header right after the gap bit
    pulse_capture();
    clear_counts();
    send_hdr(8'd1, 16'd4);
    send_data(4, 32'b1101);
    idle(1);
    send_hdr(8'd0, 16'd3);
    send_data(3, 32'b011);
    idle(3);
    check("pair_cs1_edges", 32'(c1), 32'd4);
    check("pair_cs0_edges", 32'(c0), 32'd3);
    check("pair_busy_edges", 32'(nbusy), 32'd9);
    last1 = -1; first0 = -1; overlap = 0;
    foreach (cs_log[i]) begin
      if (!cs_log[i][1]) last1 = i;
      if (!cs_log[i][0] && first0 < 0) first0 = i;
      if (cs_log[i] == 2'b00) overlap++;
    end
    check("pair_gap_ok", 32'((last1 >= 0) && (first0 - last1 >= 2)), 32'd1);
    check("pair_overlap", 32'(overlap), 32'd0);
    readback(7, obs, obs_s);
    check("pair_readback", obs, 32'b1101011);

    // Zero-length header followed immediately by a real one
    pulse_capture();
    clear_counts();
    send_hdr(8'd0, 16'd0);
    check("zero_len_busy", 32'(busy), 32'd0);
    send_hdr(8'd0, 16'd2);
    send_data(2, 32'b10);
    idle(3);
    check("zero_then_cs0_edges", 32'(c0), 32'd2);
    check("zero_then_busy_edges", 32'(nbusy), 32'd3);

    // Bad index: err is sticky across update and cleared by capture
    pulse_capture();
    clear_counts();
    send_hdr(8'd5, 16'd3);
    idle(2);
    check("bad_idx_cs_edges", 32'(c0 + c1), 32'd0);
    check("bad_idx_err", 32'(err), 32'd1);
    pulse_update();
    check("err_after_update", 32'(err), 32'd1);
    pulse_capture();
    check("err_after_capture", 32'(err), 32'd0);

    // Overflow on the 8-bit buffer: capture continues, writes stop, raddr wraps
    pulse_capture();
    clear_counts();
    send_hdr(8'd0, 16'd12);
    for (int j = 11; j >= 0; j--) begin
      clk_bit(1'b0, obs_s[0] ^ obs_s[0] ^ logic'((12'b1011_0011_1100 >> j) & 12'd1));
      if (j == 5) check("ovf_after_7", 32'(ovf_s), 32'd0);
      if (j == 4) check("ovf_after_8", 32'(ovf_s), 32'd1);
    end
    idle(3);
    check("ovf_cs_edges", 32'(cs_small), 32'd12);
    check("ovf_big_clear", 32'(ovf), 32'd0);
    check("spi_sck_follows", 32'({sck, mosi}), 32'({drck, tdi}));
    readback(9, obs, obs_s);
    check("ovf_readback_wrap", obs_s, 32'b1_0110_0111);

    // Update mid-transfer releases CS at once; a fresh header works afterwards
    pulse_capture();
    clear_counts();
    send_hdr(8'd0, 16'd8);
    send_data(3, 32'b111);
    check("abort_cs_low_before", 32'(cs_n), 32'h2);
    #1 update = 1'b1;
    #1;
    check("abort_cs_async", 32'(cs_n), 32'h3);
    check("abort_busy", 32'(busy), 32'h0);
    update = 1'b0;
    #1;
    clear_counts();
    send_hdr(8'd1, 16'd2);
    send_data(2, 32'b01);
    idle(3);
    check("rescan_cs1_edges", 32'(c1), 32'd2);
    check("rescan_cs0_edges", 32'(c0), 32'd0);
    readback(2, obs, obs_s);
    check("rescan_readback", obs, 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
